regfile_param: RTL and testbench
================================

// Module: regfile_param
// PURPOSE
//  Parametrised successor to the 32x32 MIPS register file: configurable word width and depth, optional hardwired zero register.
//  Optional write-to-read bypass. Hardware clear sequencer zeroes every register after reset or on request.
//  Sits in the CPU decode stage; feeds ALU operands and takes writeback data.
// PARAMETERS
//  WIDTH      32  data word width in bits
//  ADDR_BITS  5   register address width; DEPTH = 2**ADDR_BITS registers
//  ZERO_REG   1   1: reg[0] reads 0 and ignores writes; 0: reg[0] is an ordinary register
//  BYPASS     1   1: same-cycle write data is forwarded to matching read ports; 0: reads see stored value only
// PORTS
//  Clk            in   1          clock, all state updates on posedge
//  Reset          in   1          synchronous, active-high reset
//  ReadRegister1  in   ADDR_BITS  address for read port 1
//  ReadRegister2  in   ADDR_BITS  address for read port 2
//  ReadData1      out  WIDTH      contents at ReadRegister1 (asynchronous read)
//  ReadData2      out  WIDTH      contents at ReadRegister2 (asynchronous read)
//  WriteRegister  in   ADDR_BITS  address for write port
//  WriteData      in   WIDTH      data for write port
//  RegWrite       in   1          write enable, sampled at posedge Clk
//  ClearReq       in   1          single-cycle pulse, requests a full clear sweep
//  Busy           out  1          high while the clear sweep runs; writes are ignored
// BEHAVIOUR
//  FSM: two states, IDLE and CLEAR; sweep counter clr_idx is ADDR_BITS wide.
//  Reset = 1 at posedge: state <= CLEAR, clr_idx <= 0; register contents are not touched that edge.
//  Reset overrides everything, including an in-flight sweep: it restarts the sweep at index 0.
//  Busy = (state == CLEAR) | Reset. Busy is therefore 1 during reset and 0 only in IDLE.
//  While Reset = 1, ReadData1/ReadData2 = 0.
//  CLEAR: each posedge writes 0 to reg[clr_idx] and increments clr_idx.
//    When clr_idx == DEPTH-1, that edge writes the last register, clr_idx wraps to 0 and state <= IDLE.
//    A sweep therefore occupies exactly DEPTH cycles after Reset falls.
//  While Busy: RegWrite is ignored, ClearReq is ignored (it is not queued), ReadData1/ReadData2 = 0.
//  IDLE, ClearReq = 1: state <= CLEAR, clr_idx <= 0. A RegWrite in the same cycle is dropped; clear wins.
//  IDLE, RegWrite = 1, ClearReq = 0: reg[WriteRegister] <= WriteData at posedge.
//    If ZERO_REG = 1 and WriteRegister == 0, the write is discarded.
//  Reads: ReadDataN = reg[ReadRegisterN], combinational, no added latency.
//    If ZERO_REG = 1 and ReadRegisterN == 0, ReadDataN = 0.
//  Bypass (BYPASS = 1, IDLE, RegWrite = 1, ClearReq = 0, WriteRegister == ReadRegisterN, and not the zero register):
//    ReadDataN = WriteData in the same cycle.
//  Bypass never applies when Busy = 1 or ClearReq = 1.
//  Both read ports may address the same register and both may bypass at once.
//  Write address == read address with BYPASS = 0: the read returns the old value; the new value appears after the edge.
//  No X propagation: every register holds a defined value from the first IDLE cycle onward.
// TESTING
//  1 Reset 1 cycle, then hold idle -> Busy=1 for exactly DEPTH (32) cycles after Reset falls; then Busy=0 and all 32 registers read 0.
//  2 Write 32'hDEADBEEF to r5, then read r5 on both ports -> 32'hDEADBEEF next cycle; same cycle with BYPASS=1 also 32'hDEADBEEF.
//  3 Write 32'hFFFFFFFF to r0 with ZERO_REG=1 -> reads 0; rebuild with ZERO_REG=0 -> reads 32'hFFFFFFFF.
//  4 Fill r1..r31 with their index; pulse ClearReq together with RegWrite r7=32'h77.
//    -> Busy 32 cycles; r7 reads 0 after the sweep; a RegWrite to r3 mid-sweep is ignored (r3=0).
//  5 Assert Reset at sweep index 10 -> sweep restarts at 0, Busy stays 1 for 32 more cycles after Reset falls.
//  6 WIDTH=16, ADDR_BITS=3: write 16'hA5A5 to r7; pulse ClearReq at the end of the sweep
//    -> Busy for 8 cycles, clr_idx wraps 7->0, then IDLE; data reads correctly.

Source files
------------

// File: rtl/regfile_param.sv
// ---------------------------------------------------------------------------
// regfile_param
//   Parametrised register file for the CPU decode stage. It has two
//   asynchronous read ports and one write port that is captured on the
//   posedge of Clk. Options:
//     - a hardwired zero register (reg[0] always reads 0)
//     - write-to-read bypass, which forwards same-cycle write data to a
//       read port whose address matches the write address
//   A clear sequencer writes 0 to every register, one register per cycle.
//   It runs after Reset and whenever ClearReq is pulsed.
//
// Parameters
//   WIDTH      data word width
//   ADDR_BITS  address width, DEPTH = 2**ADDR_BITS
//   ZERO_REG   1: reg[0] reads 0 and ignores writes
//   BYPASS     1: forward same-cycle write data to matching read ports
//
// Ports
//   Clk            clock, all state changes on posedge
//   Reset          synchronous active-high reset, restarts the clear sweep
//   ReadRegister1  read port 1 address
//   ReadRegister2  read port 2 address
//   ReadData1      read port 1 data (combinational)
//   ReadData2      read port 2 data (combinational)
//   WriteRegister  write address
//   WriteData      write data
//   RegWrite       write enable
//   ClearReq       single-cycle request for a full clear sweep
//   Busy           high during Reset and while the sweep runs
// ---------------------------------------------------------------------------
module regfile_param #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 5,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [ADDR_BITS-1:0] ReadRegister1,
    input  logic [ADDR_BITS-1:0] ReadRegister2,
    output logic [WIDTH-1:0]     ReadData1,
    output logic [WIDTH-1:0]     ReadData2,
    input  logic [ADDR_BITS-1:0] WriteRegister,
    input  logic [WIDTH-1:0]     WriteData,
    input  logic                 RegWrite,
    input  logic                 ClearReq,
    output logic                 Busy
);

    localparam int                   DEPTH    = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] clr_idx_q, clr_idx_d;
    logic [WIDTH-1:0]     regs_q [DEPTH];
    logic [WIDTH-1:0]     regs_d [DEPTH];

    logic                 wr_en;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [WIDTH-1:0]     wr_data;
    logic                 fwd_ok;

    function automatic logic is_zero_reg(input logic [ADDR_BITS-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    // The sweep and the user port share one write path. Only one of them can
    // own the path in a given cycle, so a single write-enable mux is enough.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        wr_en     = 1'b0;
        wr_addr   = WriteRegister;
        wr_data   = WriteData;
        if (Reset) begin
            state_d   = ST_CLEAR;
            clr_idx_d = '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    wr_en   = 1'b1;
                    wr_addr = clr_idx_q;
                    wr_data = '0;
                    if (clr_idx_q == LAST_IDX) begin
                        state_d   = ST_IDLE;
                        clr_idx_d = '0;
                    end else begin
                        clr_idx_d = clr_idx_q + 1'b1;
                    end
                end
                default: begin
                    if (ClearReq) begin
                        // A clear request wins over a write in the same cycle.
                        state_d   = ST_CLEAR;
                        clr_idx_d = '0;
                    end else if (RegWrite && !is_zero_reg(WriteRegister)) begin
                        wr_en = 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // The storage has no reset. wr_en is held low during Reset, and the
    // sweep that follows gives every register a defined value.
    always_ff @(posedge Clk) begin
        regs_q <= regs_d;
    end

    assign Busy   = (state_q == ST_CLEAR) || Reset;
    assign fwd_ok = (BYPASS != 0) && !Busy && RegWrite && !ClearReq;

    always_comb begin
        ReadData1 = regs_q[ReadRegister1];
        if (Busy || is_zero_reg(ReadRegister1)) begin
            ReadData1 = '0;
        end else if (fwd_ok && (WriteRegister == ReadRegister1)) begin
            ReadData1 = WriteData;
        end
    end

    always_comb begin
        ReadData2 = regs_q[ReadRegister2];
        if (Busy || is_zero_reg(ReadRegister2)) begin
            ReadData2 = '0;
        end else if (fwd_ok && (WriteRegister == ReadRegister2)) begin
            ReadData2 = WriteData;
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// ---------------------------------------------------------------------------
// tb_regfile_param
//   Drives three configurations of regfile_param:
//     0: 32x32, zero register and bypass enabled
//     1: 32x32, no zero register and no bypass
//     2: 8x16,  zero register and bypass enabled
//   Each configuration has a behavioural model. A sweep is modelled as a
//   countdown; when the countdown reaches zero, every register becomes 0.
//   Directed steps also carry literal expectations.
// ---------------------------------------------------------------------------
module tb_regfile_param;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic        rst [NI];
    logic        we  [NI];
    logic        clr [NI];
    logic [4:0]  ra1 [NI];
    logic [4:0]  ra2 [NI];
    logic [4:0]  wa  [NI];
    logic [31:0] wd  [NI];

    logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
    logic [15:0] rd1_c, rd2_c;
    logic        busy_a, busy_b, busy_c;

    int checks = 0;
    int errors = 0;

    logic [31:0] mregs   [NI][32];
    int          bl      [NI];
    bit          started [NI];

    regfile_param #(.WIDTH(32), .ADDR_BITS(5), .ZERO_REG(1), .BYPASS(1)) u_a (
        .Clk(clk), .Reset(rst[0]),
        .ReadRegister1(ra1[0]), .ReadRegister2(ra2[0]),
        .ReadData1(rd1_a), .ReadData2(rd2_a),
        .WriteRegister(wa[0]), .WriteData(wd[0]),
        .RegWrite(we[0]), .ClearReq(clr[0]), .Busy(busy_a)
    );

    regfile_param #(.WIDTH(32), .ADDR_BITS(5), .ZERO_REG(0), .BYPASS(0)) u_b (
        .Clk(clk), .Reset(rst[1]),
        .ReadRegister1(ra1[1]), .ReadRegister2(ra2[1]),
        .ReadData1(rd1_b), .ReadData2(rd2_b),
        .WriteRegister(wa[1]), .WriteData(wd[1]),
        .RegWrite(we[1]), .ClearReq(clr[1]), .Busy(busy_b)
    );

    regfile_param #(.WIDTH(16), .ADDR_BITS(3), .ZERO_REG(1), .BYPASS(1)) u_c (
        .Clk(clk), .Reset(rst[2]),
        .ReadRegister1(ra1[2][2:0]), .ReadRegister2(ra2[2][2:0]),
        .ReadData1(rd1_c), .ReadData2(rd2_c),
        .WriteRegister(wa[2][2:0]), .WriteData(wd[2][15:0]),
        .RegWrite(we[2]), .ClearReq(clr[2]), .Busy(busy_c)
    );

    function automatic int p_depth(input int i);
        return (i == 2) ? 8 : 32;
    endfunction
    function automatic bit p_zero(input int i);
        return i != 1;
    endfunction
    function automatic bit p_byp(input int i);
        return i != 1;
    endfunction
    function automatic logic [31:0] p_mask(input int i);
        return (i == 2) ? 32'h0000FFFF : 32'hFFFFFFFF;
    endfunction

    function automatic logic [31:0] get_busy(input int i);
        case (i)
            0:       return {31'b0, busy_a};
            1:       return {31'b0, busy_b};
            default: return {31'b0, busy_c};
        endcase
    endfunction
    function automatic logic [31:0] get_rd1(input int i);
        case (i)
            0:       return rd1_a;
            1:       return rd1_b;
            default: return {16'h0, rd1_c};
        endcase
    endfunction
    function automatic logic [31:0] get_rd2(input int i);
        case (i)
            0:       return rd2_a;
            1:       return rd2_b;
            default: return {16'h0, rd2_c};
        endcase
    endfunction

    // Model: expected outputs, derived from the read rules.
    function automatic logic [31:0] exp_busy(input int i);
        return {31'b0, (rst[i] || bl[i] > 0)};
    endfunction
    function automatic logic [31:0] exp_rd(input int i, input logic [4:0] ra);
        if (rst[i] || bl[i] > 0) return 32'h0;
        if (p_zero(i) && ra == 5'd0) return 32'h0;
        if (p_byp(i) && we[i] && !clr[i] && wa[i] == ra) return wd[i] & p_mask(i);
        return mregs[i][ra];
    endfunction

    // Model: state update on each clock edge.
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rst[i]) begin
                started[i] <= 1'b1;
                bl[i]      <= p_depth(i);
            end else if (bl[i] > 0) begin
                bl[i] <= bl[i] - 1;
                if (bl[i] == 1) begin
                    for (int r = 0; r < 32; r++) mregs[i][r] <= 32'h0;
                end
            end else if (clr[i]) begin
                bl[i] <= p_depth(i);
            end else if (we[i] && !(p_zero(i) && wa[i] == 5'd0)) begin
                mregs[i][wa[i]] <= wd[i] & p_mask(i);
            end
        end
    end

    task automatic chk(input string nm, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] actual=%h required=%h", nm, i, act, exp);
        end
    endtask

    // Every cycle: compare each started instance against the model.
    // Inputs change at +1, count_busy probes at +2, directed checks run
    // at +3, and this compare runs at +6.
    always @(negedge clk) begin
        #6;
        for (int i = 0; i < NI; i++) begin
            if (started[i]) begin
                chk("busy", i, get_busy(i), exp_busy(i));
                chk("rd1", i, get_rd1(i), exp_rd(i, ra1[i]));
                chk("rd2", i, get_rd2(i), exp_rd(i, ra2[i]));
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic step(input int i, input logic w, input int a, input logic [31:0] d,
                        input logic c, input int r1, input int r2);
        cyc();
        we[i]  = w;
        wa[i]  = 5'(a);
        wd[i]  = d;
        clr[i] = c;
        ra1[i] = 5'(r1);
        ra2[i] = 5'(r2);
    endtask

    // Counts the cycles for which Busy stays high, with a bound of 200 cycles.
    // It can inject a write to r3, or a ClearReq, on the n-th busy cycle.
    task automatic count_busy(input int i, input int wr_at, input int clr_at, output int n);
        n = 0;
        #1;
        while (get_busy(i) == 32'd1 && n < 200) begin
            n++;
            we[i]  = (n == wr_at);
            wa[i]  = 5'd3;
            wd[i]  = 32'h33;
            clr[i] = (n == clr_at);
            @(negedge clk);
            #2;
        end
        we[i]  = 1'b0;
        clr[i] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b0; we[i] = 1'b0; clr[i] = 1'b0;
            ra1[i] = '0; ra2[i] = '0; wa[i] = '0; wd[i] = '0;
            bl[i] = 0; started[i] = 1'b0;
            for (int r = 0; r < 32; r++) mregs[i][r] = 32'h0;
        end

        // Reset for one cycle, then a 32-cycle sweep.
        cyc();
        for (int i = 0; i < NI; i++) rst[i] = 1'b1;
        ra1[0] = 5'd5;
        #2;
        chk("rst_busy", 0, {31'b0, busy_a}, 32'd1);
        chk("rst_rd", 0, rd1_a, 32'h0);
        cyc();
        for (int i = 0; i < NI; i++) rst[i] = 1'b0;
        count_busy(0, 0, 0, n);
        chk("sweep_len", 0, n, 32'd32);
        for (int r = 0; r < 32; r++) begin
            step(0, 0, 0, 0, 0, r, 31 - r);
            step(1, 0, 0, 0, 0, r, 31 - r);
            #2;
            chk("post_clr", 0, rd1_a, 32'h0);
        end

        // Write, with bypass, then read back.
        step(0, 1, 5, 32'hDEADBEEF, 0, 5, 5);
        #2;
        chk("byp_rd1", 0, rd1_a, 32'hDEADBEEF);
        chk("byp_rd2", 0, rd2_a, 32'hDEADBEEF);
        step(0, 0, 0, 0, 0, 5, 5);
        #2;
        chk("wr_rd1", 0, rd1_a, 32'hDEADBEEF);
        chk("wr_rd2", 0, rd2_a, 32'hDEADBEEF);

        // Zero register.
        step(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0);
        #2;
        chk("r0_byp", 0, rd1_a, 32'h0);
        step(0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("r0_zero", 0, rd1_a, 32'h0);
        step(1, 1, 0, 32'hFFFFFFFF, 0, 0, 5);
        #2;
        chk("nobyp_old", 1, rd1_b, 32'h0);
        step(1, 0, 0, 0, 0, 0, 5);
        #2;
        chk("r0_plain", 1, rd1_b, 32'hFFFFFFFF);
        step(1, 1, 9, 32'h12345678, 0, 9, 9);
        #2;
        chk("nobyp_r9", 1, rd2_b, 32'h0);
        step(1, 0, 0, 0, 0, 9, 9);
        #2;
        chk("r9_new", 1, rd2_b, 32'h12345678);

        // Fill the registers, then a clear that collides with a write.
        for (int r = 1; r < 32; r++) step(0, 1, r, 32'(r), 0, r, 0);
        step(0, 0, 0, 0, 0, 9, 31);
        #2;
        chk("fill9", 0, rd1_a, 32'd9);
        chk("fill31", 0, rd2_a, 32'd31);
        step(0, 1, 7, 32'h77, 1, 7, 0);
        #2;
        chk("clr_nobyp", 0, rd1_a, 32'd7);
        chk("clr_req_busy", 0, {31'b0, busy_a}, 32'd0);
        step(0, 0, 0, 0, 0, 7, 3);
        count_busy(0, 10, 5, n);
        chk("clr_len", 0, n, 32'd32);
        step(0, 0, 0, 0, 0, 7, 3);
        #2;
        chk("r7_cleared", 0, rd1_a, 32'h0);
        chk("r3_ignored", 0, rd2_a, 32'h0);

        // Reset in the middle of a sweep restarts the sweep.
        step(0, 1, 2, 32'd22, 0, 2, 2);
        step(0, 0, 0, 0, 0, 2, 2);
        #2;
        chk("r2_set", 0, rd1_a, 32'd22);
        step(0, 0, 0, 0, 1, 2, 2);
        step(0, 0, 0, 0, 0, 2, 2);
        for (int k = 0; k < 10; k++) cyc();
        rst[0] = 1'b1;
        #2;
        chk("mid_rst_busy", 0, {31'b0, busy_a}, 32'd1);
        cyc();
        rst[0] = 1'b0;
        count_busy(0, 0, 0, n);
        chk("restart_len", 0, n, 32'd32);
        step(0, 0, 0, 0, 0, 2, 2);
        #2;
        chk("r2_after", 0, rd1_a, 32'h0);

        // Small configuration: 8 x 16.
        cyc();
        rst[2] = 1'b1;
        cyc();
        rst[2] = 1'b0;
        count_busy(2, 0, 0, n);
        chk("c_rst_len", 2, n, 32'd8);
        step(2, 1, 7, 32'h0000A5A5, 0, 7, 7);
        #2;
        chk("c_byp", 2, {16'h0, rd1_c}, 32'h0000A5A5);
        step(2, 0, 0, 0, 0, 7, 7);
        #2;
        chk("c_rd", 2, {16'h0, rd2_c}, 32'h0000A5A5);
        step(2, 1, 3, 32'h00001234, 0, 3, 7);
        #2;
        chk("c_byp3", 2, {16'h0, rd1_c}, 32'h00001234);
        step(2, 0, 0, 0, 1, 7, 3);
        #2;
        chk("c_clr_req", 2, {16'h0, rd1_c}, 32'h0000A5A5);
        step(2, 0, 0, 0, 0, 7, 3);
        count_busy(2, 0, 8, n);
        chk("c_clr_len", 2, n, 32'd8);
        step(2, 0, 0, 0, 0, 7, 3);
        #2;
        chk("c_idle", 2, {31'b0, busy_c}, 32'd0);
        chk("c_r7", 2, {16'h0, rd1_c}, 32'h0);

        cyc();
        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
